// File: rtl/intc_pkg.sv
// =============================================================================
// Module      : intc_pkg
// Description : Shared constants, register-select enum and decode helper for
//               the APB interrupt controller.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package intc_pkg;

    localparam int c_max_src = 32;

    localparam logic [11:0] c_off_pending = 12'h000;
    localparam logic [11:0] c_off_enable  = 12'h004;
    localparam logic [11:0] c_off_type    = 12'h008;
    localparam logic [11:0] c_off_claim   = 12'h00C;

    typedef enum logic [1:0] {
        REG_PENDING = c_off_pending[3:2],
        REG_ENABLE  = c_off_enable[3:2],
        REG_TYPE    = c_off_type[3:2],
        REG_CLAIM   = c_off_claim[3:2]
    } reg_sel_e;

    // Only the first 16-byte window of the 4 KiB page carries registers.
    function automatic logic is_mapped(input logic [7:0] page);
        return (page == 8'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/intc_gateway.sv
// =============================================================================
// Module      : intc_gateway
// Description : Per-source capture: level sources follow the registered input,
//               edge sources latch a rising edge until cleared.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module intc_gateway (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    input  logic src_type,
    input  logic clr,
    output logic pending
);

    logic r_prev;
    logic r_edge_pend;

    // Edge state is held at 0 while the source is level-typed, so a switch in
    // either direction starts from a clean slate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev      <= 1'b0;
            r_edge_pend <= 1'b0;
        end else begin
            r_prev <= src;
            if (!src_type) begin
                r_edge_pend <= 1'b0;
            end else begin
                r_edge_pend <= (src & ~r_prev) | (r_edge_pend & ~clr);
            end
        end
    end

    assign pending = src_type ? r_edge_pend : r_prev;

endmodule

`default_nettype wire

// File: rtl/apb_intc.sv
// =============================================================================
// Module      : apb_intc
// Description : APB-mapped interrupt controller, fixed priority by index.
//               Optional macro APB_INTC_SLVERR_EN enables pslverr reporting.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module apb_intc
    import intc_pkg::*;
#(
    parameter int SRC_CNT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        paddr,
    input  logic [31:0]        pwdata,
    input  logic               pwrite,
    input  logic               psel,
    input  logic               penable,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    input  logic [SRC_CNT-1:0] src_i,
    output logic               irq_o
);

    logic               w_access;
    logic               w_mapped;
    reg_sel_e           w_sel;
    logic               w_wr;
    logic               w_rd;
    logic [SRC_CNT-1:0] r_enable;
    logic [SRC_CNT-1:0] r_type;
    logic               r_irq;
    logic [SRC_CNT-1:0] w_pending;
    logic [SRC_CNT-1:0] w_active;
    logic [SRC_CNT-1:0] w_clr;
    logic [SRC_CNT-1:0] w_claim_onehot;
    logic [5:0]         w_claim_id;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_access = psel & penable;
    assign w_mapped = is_mapped(paddr[11:4]);
    assign w_sel    = reg_sel_e'(paddr[3:2]);
    assign w_wr     = w_access & pwrite & w_mapped;
    assign w_rd     = w_access & ~pwrite & w_mapped;
    assign w_unused = ^{paddr[31:12], paddr[1:0], pwdata};

    assign pready = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable <= '0;
            r_type   <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && (w_sel == REG_ENABLE)) begin
                r_enable <= pwdata[SRC_CNT-1:0];
            end
            if (w_wr && (w_sel == REG_TYPE)) begin
                r_type <= pwdata[SRC_CNT-1:0];
            end
            r_irq <= |w_active;
        end
    end

    assign irq_o    = r_irq;
    assign w_active = w_pending & r_enable;

    // Descending scan so the lowest active index wins.
    always_comb begin
        w_claim_id     = '0;
        w_claim_onehot = '0;
        for (int i = SRC_CNT - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_claim_id        = 6'(i + 1);
                w_claim_onehot    = '0;
                w_claim_onehot[i] = 1'b1;
            end
        end
    end

    assign w_clr = ({SRC_CNT{w_wr && (w_sel == REG_PENDING)}} & pwdata[SRC_CNT-1:0])
                 | ({SRC_CNT{w_rd && (w_sel == REG_CLAIM)}}   & w_claim_onehot);

    for (genvar g = 0; g < SRC_CNT; g++) begin : g_gateway
        intc_gateway u_gateway (
            .clk      (clk),
            .rst_n    (rst_n),
            .src      (src_i[g]),
            .src_type (r_type[g]),
            .clr      (w_clr[g]),
            .pending  (w_pending[g])
        );
    end

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_sel)
                REG_PENDING: w_rdata[SRC_CNT-1:0] = w_pending;
                REG_ENABLE:  w_rdata[SRC_CNT-1:0] = r_enable;
                REG_TYPE:    w_rdata[SRC_CNT-1:0] = r_type;
                REG_CLAIM:   w_rdata[5:0]         = w_claim_id;
                default:     w_rdata              = '0;
            endcase
        end
    end

    assign prdata = w_rdata;

`ifdef APB_INTC_SLVERR_EN
    assign pslverr = rst_n & w_access & (~w_mapped | (pwrite & (w_sel == REG_CLAIM)));
`else
    assign pslverr = 1'b0;
`endif

endmodule

`default_nettype wire
